cnmi_phase_sequencer: RTL and testbench
=======================================

// Module: cnmi_phase_sequencer
// PURPOSE
//  Generates the CNMI machine-cycle state that the CNMI phase decoder consumes.
//  - Synchronises the NMI pin and latches a pending NMI.
//  - Starts the CNMI cycle at an instruction boundary and drives notCNMI plus XPT/notXPT phase steps 1..XPT_LAST.
//  - Retires the cycle using the decoder's XPT-reset, CNMI-reset and CM1-set strobes.
//  - Owns IFF1/IFF2 save/clear on NMI entry.
// PARAMETERS
//  XPT_LAST     10  final phase; decoder's terminal strobes are only legal at this phase
//  SYNC_STAGES  2   NMI pin synchroniser depth (>=2)
// PORTS
//  CLK            in   1  clock, all state on rising edge
//  notRESET       in   1  asynchronous, active-low reset
//  notNMI_pin     in   1  asynchronous NMI request, falling-edge triggered, idle high
//  M1_END         in   1  instruction boundary strobe; a pending NMI is taken here
//  STEP           in   1  phase advance enable (low = wait state, XPT holds)
//  PR_Reset_XPT   in   1  decoder strobe: return XPT to 0
//  P2_Reset_CNMI  in   1  decoder strobe: end CNMI cycle
//  P2_Set_CM1     in   1  decoder strobe: request next M1 fetch
//  M1_ACK         in   1  fetch unit accepted the M1 request; clears CM1
//  EI, DI, RETN   in   1  IFF update strobes from the instruction decoder
//  XPT            out  4  phase counter, 0 outside CNMI
//  notXPT         out  4  bitwise ~XPT, registered alongside XPT, never skewed
//  notCNMI        out  1  low while CNMI cycle active
//  CM1            out  1  level: next cycle is M1
//  NMI_PENDING    out  1  edge latched, not yet serviced
//  IFF1, IFF2     out  1  interrupt enable flip-flops
//  ERR            out  1  sticky protocol-violation flag
// BEHAVIOUR
//  Reset values (async): XPT=0, notXPT=4'hF, notCNMI=1, CM1=0, NMI_PENDING=0, IFF1=IFF2=0, ERR=0, sync chain=1.
//  Edge detect:
//  - A falling edge on the last sync stage sets NMI_PENDING.
//  - Pin-to-NMI_PENDING latency is SYNC_STAGES+1 clocks.
//  - Low pulses shorter than 1 clock are not guaranteed.
//  - A held-low pin gives exactly one request.
//  FSM IDLE / PENDING / ACTIVE; state is implied by NMI_PENDING and notCNMI.
//  - IDLE -> PENDING on edge.
//  - PENDING -> ACTIVE on the first M1_END with registered NMI_PENDING=1.
//  - An edge detected in the same cycle as M1_END waits for the next boundary.
//  Entry (one edge):
//  - notCNMI<=0, XPT<=1, NMI_PENDING<=0.
//  - IFF2<=IFF1, IFF1<=0.
//  - M1_END is ignored while ACTIVE.
//  ACTIVE stepping:
//  - XPT increments by 1 on each STEP=1 edge while XPT<XPT_LAST.
//  - STEP=0 holds XPT.
//  Terminal phase (XPT==XPT_LAST, STEP=1), each strobe acts independently:
//  - PR_Reset_XPT -> XPT<=0.
//  - P2_Reset_CNMI -> notCNMI<=1, returning to IDLE or PENDING.
//  - P2_Set_CM1 -> CM1<=1.
//  - CM1 clears on M1_ACK; if set and ack coincide, set wins.
//  Errors (sets ERR; ERR clears only by reset):
//  - STEP at XPT_LAST with no PR_Reset_XPT: XPT holds at XPT_LAST.
//  - Any terminal strobe outside ACTIVE or before XPT_LAST: strobe ignored.
//  Queueing:
//  - A new edge while ACTIVE sets NMI_PENDING, serviced at the next M1_END after exit.
//  - Further edges while pending merge into one request.
//  IFF priority per cycle: NMI entry > DI (both 0) > EI (both 1) > RETN (IFF1<=IFF2).
//  Reset mid-cycle aborts at once to reset values; a pin already low at release gives no request.
// TESTING
//  1. Pin falls at t0, M1_END at t0+5 -> NMI_PENDING=1 at t0+3; notCNMI=0 and XPT=1 after t0+5 edge; IFF1=0, IFF2=prior IFF1.
//  2. Full cycle, STEP=1 always, strobes at XPT=10 -> XPT 1..10 then 0; notCNMI=1 and CM1=1 same edge; M1_ACK clears CM1; ERR=0.
//  3. STEP low 3 clocks at XPT=6 -> XPT holds 6, notXPT holds 4'h9, then resumes 7; total cycle length +3.
//  4. Second pin edge at XPT=4 -> NMI_PENDING=1; after exit, next M1_END restarts XPT=1.
//  5. PR_Reset_XPT at XPT=7 -> ignored, XPT=8 next, ERR=1; STEP at 10 w/o reset -> XPT stays 10.
//  6. notRESET low at XPT=5 -> immediate reset values; pin held low across release -> NMI_PENDING stays 0.

Source files
------------

// File: rtl/cnmi_phase_sequencer.sv
// -----------------------------------------------------------------------------
// cnmi_phase_sequencer
//
// Produces the CNMI machine-cycle state that the CNMI phase decoder consumes.
// It synchronises the NMI pin and latches one pending request per falling
// edge. At the next instruction boundary it starts the CNMI cycle. It then
// steps the XPT phase counter 1..XPT_LAST and retires the cycle from the
// decoder's terminal strobes. It also saves and clears IFF1/IFF2 on NMI entry.
//
// Ports
//   CLK, notRESET     clock (rising edge), asynchronous active-low reset
//   notNMI_pin        asynchronous NMI request, falling-edge triggered
//   M1_END            instruction boundary; a pending NMI is taken here
//   STEP              phase advance enable (low = wait state)
//   PR_Reset_XPT      terminal strobe: return XPT to 0
//   P2_Reset_CNMI     terminal strobe: end the CNMI cycle
//   P2_Set_CM1        terminal strobe: request the next M1 fetch
//   M1_ACK            fetch unit accepted the M1 request (clears CM1)
//   EI, DI, RETN      interrupt-enable update strobes
//   XPT / notXPT      phase counter and its registered complement
//   notCNMI           low while the CNMI cycle is active
//   CM1               next cycle is M1
//   NMI_PENDING       request latched, not yet serviced
//   IFF1, IFF2        interrupt enable flip-flops
//   ERR               sticky protocol-violation flag
// -----------------------------------------------------------------------------
module cnmi_phase_sequencer #(
  parameter int unsigned XPT_LAST    = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       notRESET,
  input  logic       notNMI_pin,
  input  logic       M1_END,
  input  logic       STEP,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Reset_CNMI,
  input  logic       P2_Set_CM1,
  input  logic       M1_ACK,
  input  logic       EI,
  input  logic       DI,
  input  logic       RETN,
  output logic [3:0] XPT,
  output logic [3:0] notXPT,
  output logic       notCNMI,
  output logic       CM1,
  output logic       NMI_PENDING,
  output logic       IFF1,
  output logic       IFF2,
  output logic       ERR
);

  localparam logic [3:0] XPT_END = 4'(XPT_LAST);

  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} phase_e;

  // Synchroniser, edge detector and warm-up qualifier.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   pin_prev_q;
  logic                   nmi_fall;

  // Architectural state and its next values.
  logic [3:0] xpt_q, xpt_d, nxpt_q;
  logic       cnmi_n_q, cnmi_n_d;
  logic       cm1_q, cm1_d;
  logic       pend_q, pend_d;
  logic       iff1_q, iff1_d;
  logic       iff2_q, iff2_d;
  logic       err_q, err_d;

  phase_e phase;
  logic   entry, at_term, term_step, strobe_any;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      // NOTE: the sync chain resets to the idle (high) pin level. vld_q marks
      // which stages hold real pin samples, so a pin that is already low at
      // release never looks like a falling edge.
      sync_q     <= '1;
      vld_q      <= '0;
      pin_prev_q <= 1'b1;
      xpt_q      <= 4'h0;
      nxpt_q     <= 4'hF;
      cnmi_n_q   <= 1'b1;
      cm1_q      <= 1'b0;
      pend_q     <= 1'b0;
      iff1_q     <= 1'b0;
      iff2_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], notNMI_pin};
      vld_q      <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      pin_prev_q <= sync_q[SYNC_STAGES-1];
      xpt_q      <= xpt_d;
      nxpt_q     <= ~xpt_d;  // complement comes from the same next value, so it is never skewed
      cnmi_n_q   <= cnmi_n_d;
      cm1_q      <= cm1_d;
      pend_q     <= pend_d;
      iff1_q     <= iff1_d;
      iff2_q     <= iff2_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Falling edge on the last stage. The edge is only valid once the previous
  // sample is a real pin sample, not a reset value.
  assign nmi_fall = vld_q[SYNC_STAGES] & pin_prev_q & ~sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    phase = IDLE;
    if (!cnmi_n_q)   phase = ACTIVE;
    else if (pend_q) phase = PENDING;

    entry      = (phase == PENDING) && M1_END;
    at_term    = (phase == ACTIVE) && (xpt_q == XPT_END);
    term_step  = at_term && STEP;
    strobe_any = PR_Reset_XPT | P2_Reset_CNMI | P2_Set_CM1;

    xpt_d    = xpt_q;
    cnmi_n_d = cnmi_n_q;
    cm1_d    = cm1_q;
    pend_d   = pend_q;
    iff1_d   = iff1_q;
    iff2_d   = iff2_q;
    err_d    = err_q;

    if (entry) begin
      cnmi_n_d = 1'b0;
      xpt_d    = 4'd1;
      pend_d   = 1'b0;
    end else if (phase == ACTIVE && STEP) begin
      if (xpt_q < XPT_END)   xpt_d = xpt_q + 4'd1;
      else if (PR_Reset_XPT) xpt_d = 4'd0;
      else                   err_d = 1'b1;  // stepping past the last phase: hold
    end

    // A new edge always queues a request. Edges that arrive while a request
    // is already pending merge into it.
    if (nmi_fall) pend_d = 1'b1;

    if (term_step && P2_Reset_CNMI) cnmi_n_d = 1'b0 | 1'b1;

    // Set takes priority over the acknowledge.
    if (term_step && P2_Set_CM1) cm1_d = 1'b1;
    else if (M1_ACK)             cm1_d = 1'b0;

    // Terminal strobes outside the final ACTIVE phase are ignored and flagged.
    if (strobe_any && !at_term) err_d = 1'b1;

    if (entry) begin
      iff2_d = iff1_q;
      iff1_d = 1'b0;
    end else if (DI) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end else if (EI) begin
      iff1_d = 1'b1;
      iff2_d = 1'b1;
    end else if (RETN) begin
      iff1_d = iff2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    XPT         = xpt_q;
    notXPT      = nxpt_q;
    notCNMI     = cnmi_n_q;
    CM1         = cm1_q;
    NMI_PENDING = pend_q;
    IFF1        = iff1_q;
    IFF2        = iff2_q;
    ERR         = err_q;
  end

endmodule

// File: tb/tb_cnmi_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnmi_phase_sequencer
//
// Directed bench for cnmi_phase_sequencer. The stimulus drives inputs on the
// falling clock edge and pushes the expected register values for the next
// cycle into a scoreboard. A separate monitor pops due entries on each falling
// edge and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_cnmi_phase_sequencer;

  typedef enum int {S_XPT, S_NXPT, S_CNMI_N, S_CM1, S_PEND, S_IFF1, S_IFF2, S_ERR} sig_e;

  typedef struct {
    int         cyc;
    sig_e       sel;
    logic [3:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       CLK = 1'b0;
  logic       notRESET = 1'b0;
  logic       notNMI_pin = 1'b1;
  logic       M1_END = 1'b0, STEP = 1'b0;
  logic       PR_Reset_XPT = 1'b0, P2_Reset_CNMI = 1'b0, P2_Set_CM1 = 1'b0;
  logic       M1_ACK = 1'b0, EI = 1'b0, DI = 1'b0, RETN = 1'b0;
  logic [3:0] XPT, notXPT;
  logic       notCNMI, CM1, NMI_PENDING, IFF1, IFF2, ERR;

  cnmi_phase_sequencer #(.XPT_LAST(10), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .notRESET(notRESET), .notNMI_pin(notNMI_pin), .M1_END(M1_END),
    .STEP(STEP), .PR_Reset_XPT(PR_Reset_XPT), .P2_Reset_CNMI(P2_Reset_CNMI),
    .P2_Set_CM1(P2_Set_CM1), .M1_ACK(M1_ACK), .EI(EI), .DI(DI), .RETN(RETN),
    .XPT(XPT), .notXPT(notXPT), .notCNMI(notCNMI), .CM1(CM1),
    .NMI_PENDING(NMI_PENDING), .IFF1(IFF1), .IFF2(IFF2), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [3:0] actual(sig_e s);
    case (s)
      S_XPT:    return XPT;
      S_NXPT:   return notXPT;
      S_CNMI_N: return {3'b0, notCNMI};
      S_CM1:    return {3'b0, CM1};
      S_PEND:   return {3'b0, NMI_PENDING};
      S_IFF1:   return {3'b0, IFF1};
      S_IFF2:   return {3'b0, IFF2};
      default:  return {3'b0, ERR};
    endcase
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every scoreboard entry that is due this cycle.
  initial begin
    forever begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: checked at cycle %0d, due at cycle %0d", e.name, cyc, e.cyc);
        end else begin
          check(e.name, actual(e.sel), e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit (%0d tests, %0d failed)", n_tests, n_fail);
    $fatal(1);
  end

  // ---- stimulus helpers -----------------------------------------------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic expect_next(sig_e sel, logic [3:0] val, string name);
    sb.push_back('{cyc + 1, sel, val, name});
  endtask

  task automatic expect_xpt(string tag, logic [3:0] v);
    expect_next(S_XPT, v, {tag, "_xpt"});
    expect_next(S_NXPT, ~v, {tag, "_notxpt"});
  endtask

  task automatic expect_reset_values(string tag);
    expect_xpt(tag, 4'h0);
    expect_next(S_CNMI_N, 4'd1, {tag, "_notcnmi"});
    expect_next(S_CM1,    4'd0, {tag, "_cm1"});
    expect_next(S_PEND,   4'd0, {tag, "_pend"});
    expect_next(S_IFF1,   4'd0, {tag, "_iff1"});
    expect_next(S_IFF2,   4'd0, {tag, "_iff2"});
    expect_next(S_ERR,    4'd0, {tag, "_err"});
  endtask

  // Pin falls now (t0). The request is pending at t0+3 and taken at t0+5.
  task automatic start_nmi(string tag, logic [3:0] exp_iff2);
    notNMI_pin = 1'b0;
    tick();
    expect_next(S_PEND, 4'd0, {tag, "_pend_t2"});
    tick();
    expect_next(S_PEND, 4'd1, {tag, "_pend_t3"});
    tick();
    tick();
    M1_END = 1'b1;
    expect_xpt({tag, "_entry"}, 4'd1);
    expect_next(S_CNMI_N, 4'd0,     {tag, "_entry_notcnmi"});
    expect_next(S_PEND,   4'd0,     {tag, "_entry_pend"});
    expect_next(S_IFF1,   4'd0,     {tag, "_entry_iff1"});
    expect_next(S_IFF2,   exp_iff2, {tag, "_entry_iff2"});
    tick();
    M1_END     = 1'b0;
    notNMI_pin = 1'b1;
  endtask

  task automatic run_phases(string tag, int from, int to);
    for (int v = from; v <= to; v++) begin
      STEP = 1'b1;
      expect_xpt(tag, 4'(v));
      tick();
    end
  endtask

  task automatic finish_cycle(string tag, logic ack, logic [3:0] exp_pend, logic [3:0] exp_err);
    STEP = 1'b1; PR_Reset_XPT = 1'b1; P2_Reset_CNMI = 1'b1; P2_Set_CM1 = 1'b1;
    M1_ACK = ack;
    expect_xpt({tag, "_exit"}, 4'd0);
    expect_next(S_CNMI_N, 4'd1,     {tag, "_exit_notcnmi"});
    expect_next(S_CM1,    4'd1,     {tag, "_exit_cm1"});
    expect_next(S_PEND,   exp_pend, {tag, "_exit_pend"});
    expect_next(S_ERR,    exp_err,  {tag, "_exit_err"});
    tick();
    STEP = 1'b0; PR_Reset_XPT = 1'b0; P2_Reset_CNMI = 1'b0; P2_Set_CM1 = 1'b0;
    M1_ACK = 1'b0;
  endtask

  task automatic ack_cm1(string tag);
    M1_ACK = 1'b1;
    expect_next(S_CM1, 4'd0, {tag, "_ack_cm1"});
    tick();
    M1_ACK = 1'b0;
  endtask

  // ---- directed sequence ----------------------------------------------------
  initial begin
    tick();
    tick();
    expect_reset_values("reset");
    tick();
    notRESET = 1'b1;
    repeat (4) tick();

    // IFF strobes: DI has priority over EI.
    EI = 1'b1;
    expect_next(S_IFF1, 4'd1, "ei_iff1");
    expect_next(S_IFF2, 4'd1, "ei_iff2");
    tick();
    DI = 1'b1;
    expect_next(S_IFF1, 4'd0, "di_over_ei_iff1");
    expect_next(S_IFF2, 4'd0, "di_over_ei_iff2");
    tick();
    DI = 1'b0;
    expect_next(S_IFF1, 4'd1, "ei2_iff1");
    tick();
    EI = 1'b0;

    // 1: entry latency and IFF save (IFF1 was 1)
    start_nmi("t1", 4'd1);

    // 2: full cycle with all terminal strobes at XPT=10
    run_phases("t2", 2, 10);
    finish_cycle("t2", 1'b0, 4'd0, 4'd0);
    ack_cm1("t2");

    // 3: three wait states at XPT=6; set beats a coincident ack
    start_nmi("t3", 4'd0);
    run_phases("t3", 2, 6);
    STEP = 1'b0;
    repeat (3) begin
      expect_xpt("t3_hold", 4'd6);
      tick();
    end
    run_phases("t3", 7, 10);
    finish_cycle("t3_setwins", 1'b1, 4'd0, 4'd0);
    ack_cm1("t3");

    // 4: second edge during the cycle queues; M1_END while active is ignored
    start_nmi("t4", 4'd0);
    run_phases("t4", 2, 4);
    notNMI_pin = 1'b0;
    run_phases("t4", 5, 6);
    STEP = 1'b1;
    expect_xpt("t4", 4'd7);
    expect_next(S_PEND, 4'd1, "t4_queued_pend");
    tick();
    M1_END = 1'b1;
    expect_xpt("t4_m1end_ignored", 4'd8);
    expect_next(S_CNMI_N, 4'd0, "t4_m1end_ignored_notcnmi");
    expect_next(S_PEND,   4'd1, "t4_m1end_ignored_pend");
    tick();
    M1_END = 1'b0;
    notNMI_pin = 1'b1;
    run_phases("t4", 9, 10);
    finish_cycle("t4", 1'b0, 4'd1, 4'd0);
    ack_cm1("t4");
    M1_END = 1'b1;
    expect_xpt("t4_restart", 4'd1);
    expect_next(S_CNMI_N, 4'd0, "t4_restart_notcnmi");
    expect_next(S_PEND,   4'd0, "t4_restart_pend");
    tick();
    M1_END = 1'b0;

    // 5: early PR_Reset_XPT is ignored and flagged; STEP at 10 without reset holds
    run_phases("t5", 2, 7);
    STEP = 1'b1; PR_Reset_XPT = 1'b1;
    expect_xpt("t5_early_reset", 4'd8);
    expect_next(S_ERR, 4'd1, "t5_early_reset_err");
    tick();
    PR_Reset_XPT = 1'b0;
    run_phases("t5", 9, 10);
    STEP = 1'b1;
    expect_xpt("t5_hold_last", 4'd10);
    expect_next(S_ERR, 4'd1, "t5_hold_last_err");
    tick();
    finish_cycle("t5", 1'b0, 4'd0, 4'd1);
    ack_cm1("t5");
    P2_Set_CM1 = 1'b1;
    expect_next(S_CM1, 4'd0, "t5_idle_set_cm1_ignored");
    tick();
    P2_Set_CM1 = 1'b0;

    // 6: reset mid-cycle; pin held low across release gives no request
    start_nmi("t6", 4'd0);
    run_phases("t6", 2, 5);
    #2;
    notRESET   = 1'b0;
    notNMI_pin = 1'b0;
    expect_reset_values("t6_reset");
    tick();
    tick();
    notRESET = 1'b1;
    repeat (6) begin
      expect_next(S_PEND,   4'd0, "t6_no_request_pend");
      expect_next(S_CNMI_N, 4'd1, "t6_no_request_notcnmi");
      tick();
    end
    M1_END = 1'b1;
    expect_xpt("t6_no_entry", 4'd0);
    expect_next(S_CNMI_N, 4'd1, "t6_no_entry_notcnmi");
    tick();
    M1_END = 1'b0;
    notNMI_pin = 1'b1;

    tick();
    tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries never checked", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
